// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {b_out, diff} = a - b - b_in, LSB first,
// one bit per clock behind a start/done handshake.
module serial_subtractor #(
  parameter int width = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [width:0] a,
  input  logic [width:0] b,
  input  logic           b_in,
  output logic           busy,
  output logic           done,
  output logic [width:0] diff,
  output logic           b_out
);

  localparam int cnt_w = (width < 1) ? 1 : $clog2(width + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [width:0]     sa_reg;
  logic [width:0]     sb_reg;
  logic               borrow_reg;
  logic [width:0]     res_reg;
  logic [cnt_w-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [width:0]     diff_reg;
  logic               b_out_reg;

  logic               d_bit;
  logic               borrow_next;
  logic [width+1:0]   res_ext;
  logic [width:0]     res_next;

  assign d_bit       = sa_reg[0] ^ sb_reg[0] ^ borrow_reg;
  assign borrow_next = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & borrow_reg);
  // New bit enters at the MSB; after width+1 shifts the LSB lands at bit 0.
  assign res_ext     = {d_bit, res_reg};
  assign res_next    = res_ext[width+1:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      borrow_reg <= 1'b0;
      res_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      b_out_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            sa_reg     <= a;
            sb_reg     <= b;
            borrow_reg <= b_in;
            res_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sa_reg     <= sa_reg >> 1;
          sb_reg     <= sb_reg >> 1;
          borrow_reg <= borrow_next;
          res_reg    <= res_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == last_cnt) begin
            diff_reg  <= res_next;
            b_out_reg <= borrow_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign diff  = diff_reg;
  assign b_out = b_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Checks serial_subtractor at width=2 and width=4 against plain modular
// arithmetic, including handshake timing, back-to-back, and mid-run reset.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start2 = 1'b0, b_in2 = 1'b0;
  logic [2:0] a2 = '0, b2 = '0;
  logic       busy2, done2, b_out2;
  logic [2:0] diff2;

  logic       start4 = 1'b0, b_in4 = 1'b0;
  logic [4:0] a4 = '0, b4 = '0;
  logic       busy4, done4, b_out4;
  logic [4:0] diff4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.width(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .b_in(b_in2),
    .busy(busy2), .done(done2), .diff(diff2), .b_out(b_out2)
  );

  serial_subtractor #(.width(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .b_in(b_in4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(b_out4)
  );

  // Reference: unsigned subtraction modulo 2^(w+1), borrow when a < b + b_in.
  function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                  output int d, output int bo);
    d  = (a - b - bin) & ((1 << (w + 1)) - 1);
    bo = (a < b + bin) ? 1 : 0;
  endfunction

  // Runs one width=2 operation from a negedge; reports results and timing.
  task automatic op2(input int a, input int b, input int bin, output int d, output int bo,
                     output int lat, output int busy_cnt, output int overlap);
    a2 = 3'(a); b2 = 3'(b); b_in2 = bin[0]; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0; overlap = 0;
    busy_cnt = busy2 ? 1 : 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy2) busy_cnt++;
      if (busy2 && done2) overlap = 1;
    end
    d = int'(diff2); bo = int'(b_out2);
  endtask

  task automatic op4(input int a, input int b, input int bin, output int d, output int bo,
                     output int lat);
    a4 = 5'(a); b4 = 5'(b); b_in4 = bin[0]; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = int'(diff4); bo = int'(b_out4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy2, done2, diff2, b_out2} !== 6'b0) begin
      fails++;
      $display("FAIL reset_w2: busy=%b done=%b diff=%0d b_out=%b, required all 0",
               busy2, done2, diff2, b_out2);
    end
    tests++;
    if ({busy4, done4, diff4, b_out4} !== 8'b0) begin
      fails++;
      $display("FAIL reset_w4: busy=%b done=%b diff=%0d b_out=%b, required all 0",
               busy4, done4, diff4, b_out4);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy2, done2, diff2, b_out2} !== 6'b0) begin
      fails++;
      $display("FAIL idle_before_start: busy=%b done=%b diff=%0d b_out=%b, required all 0",
               busy2, done2, diff2, b_out2);
    end
  endtask

  task automatic test_basic;
    int d, bo, lat, bc, ov;
    op2(5, 3, 0, d, bo, lat, bc, ov);
    tests++;
    if (d !== 2 || bo !== 0) begin
      fails++;
      $display("FAIL basic_result: diff=%0d b_out=%0d, required diff=2 b_out=0", d, bo);
    end
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL basic_latency: %0d cycles, required 3", lat);
    end
    tests++;
    if (bc !== 3 || ov !== 0) begin
      fails++;
      $display("FAIL basic_busy: busy cycles=%0d overlap=%0d, required 3 and 0", bc, ov);
    end
    @(negedge clk);
    tests++;
    if (done2 !== 1'b0 || diff2 !== 3'd2) begin
      fails++;
      $display("FAIL basic_hold: done=%b diff=%0d, required done=0 diff=2", done2, diff2);
    end
  endtask

  task automatic test_underflow;
    int ta[3] = '{3, 7, 0};
    int tb_[3] = '{5, 7, 0};
    int tc[3] = '{0, 1, 0};
    int d, bo, lat, bc, ov, ed, eb;
    for (int i = 0; i < 3; i++) begin
      op2(ta[i], tb_[i], tc[i], d, bo, lat, bc, ov);
      ref_sub(2, ta[i], tb_[i], tc[i], ed, eb);
      tests++;
      if (d !== ed || bo !== eb || lat !== 3) begin
        fails++;
        $display("FAIL underflow_%0d: diff=%0d b_out=%0d lat=%0d, required diff=%0d b_out=%0d lat=3",
                 i, d, bo, lat, ed, eb);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 24; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      rc = int'($urandom_range(0, 1));
      op2(ra, rb, rc, d, bo, lat, bc, ov);
      ref_sub(2, ra, rb, rc, ed, eb);
      tests++;
      if (d !== ed || bo !== eb || lat !== 3 || ov !== 0) begin
        fails++;
        $display("FAIL random_w2 a=%0d b=%0d bin=%0d: diff=%0d b_out=%0d lat=%0d ov=%0d, required diff=%0d b_out=%0d lat=3 ov=0",
                 ra, rb, rc, d, bo, lat, ov, ed, eb);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    a2 = 3'd2; b2 = 3'd3; b_in2 = 1'b0; start2 = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (diff2 !== 3'd7 || b_out2 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: diff=%0d b_out=%b, required diff=7 b_out=1", diff2, b_out2);
    end
    a2 = 3'd6; b2 = 3'd1;
    @(negedge clk);
    start2 = 1'b0;
    tests++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b done=%b, required busy=1 done=0", busy2, done2);
    end
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (diff2 !== 3'd5 || b_out2 !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL b2b_second: diff=%0d b_out=%b lat=%0d, required diff=5 b_out=0 lat=3",
               diff2, b_out2, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_run_inputs;
    int lat, extra;
    a2 = 3'd6; b2 = 3'd2; b_in2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1; a2 = 3'd1; b2 = 3'd7; b_in2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 2;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (diff2 !== 3'd4 || b_out2 !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL midrun_result: diff=%0d b_out=%b lat=%0d, required diff=4 b_out=0 lat=3",
               diff2, b_out2, lat);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy2 || done2) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL midrun_no_extra_op: %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    a2 = 3'd5; b2 = 3'd1; b_in2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || diff2 !== 3'd0 || b_out2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op: busy=%b done=%b diff=%0d b_out=%b, required all 0",
               busy2, done2, diff2, b_out2);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done2 || busy2) seen++;
    end
    tests++;
    if (seen !== 0 || diff2 !== 3'd0) begin
      fails++;
      $display("FAIL reset_no_done: active cycles=%0d diff=%0d, required 0 and 0", seen, diff2);
    end
  endtask

  task automatic test_sweep_w4;
    int d, bo, lat, ed, eb;
    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op4(ia, ib, ic, d, bo, lat);
          ref_sub(4, ia, ib, ic, ed, eb);
          tests++;
          if (d !== ed || bo !== eb || lat !== 5) begin
            fails++;
            $display("FAIL sweep_w4 a=%0d b=%0d bin=%0d: diff=%0d b_out=%0d lat=%0d, required diff=%0d b_out=%0d lat=5",
                     ia, ib, ic, d, bo, lat, ed, eb);
          end
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_underflow;
    test_back_to_back;
    test_mid_run_inputs;
    test_reset_mid_op;
    test_sweep_w4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
